// File: rtl/qdiff_thresh_seq.sv
// rtl/qdiff_thresh_seq.sv - sequential sign-magnitude difference and threshold unit
//
// Purpose: for each of CH channels, one at a time through a shared path, form
// a sign-magnitude difference and compare it against thresholds. The unit
// produces registered per-channel results and a count of "greater" hits.
//
// Ports:
//   clk       clock; all state changes on its rising edge
//   rst       synchronous active-low reset
//   start     one-cycle request, accepted only in IDLE
//   mode      0: d = x - xp vs hi_th/lo_th; 1: d = xp - offset, x vs d
//   x_in      packed operand x, channel c at [c*N +: N]
//   xp_in     packed operand xp
//   offset    mode-1 subtrahend
//   hi_th     mode-0 upper threshold
//   lo_th     mode-0 lower threshold
//   diff_out  registered d per channel
//   gt_flags  per-channel "greater" result
//   lt_flags  per-channel "less" result
//   count_gt  population count of gt_flags
//   busy      high from the cycle after accepted start through DONE
//   done      one-cycle pulse when all results are valid
module qdiff_thresh_seq #(
   parameter int N  = 32,
   parameter int Q  = 16,
   parameter int CH = 4,
   parameter int CW = $clog2(CH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [CH*N-1:0]   x_in,
   input  logic [CH*N-1:0]   xp_in,
   input  logic [N-1:0]      offset,
   input  logic [N-1:0]      hi_th,
   input  logic [N-1:0]      lo_th,
   output logic [CH*N-1:0]   diff_out,
   output logic [CH-1:0]     gt_flags,
   output logic [CH-1:0]     lt_flags,
   output logic [CW-1:0]     count_gt,
   output logic              busy,
   output logic              done
);

   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

   // Q only sets the binary point; arithmetic is format-agnostic, but the
   // fraction must fit inside the magnitude field.
   if (Q > N - 1) begin : g_q_range_check
      $error("qdiff_thresh_seq: Q must not exceed N-1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SUB  = 2'd1,
      S_CMP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Sign-magnitude add: saturating magnitude, zero always normalised to +0.
   function automatic logic [N-1:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] mag_sum;
      logic [N-1:0] r;
      mag_sum = '0;
      r       = '0;
      if (a[N-1] == b[N-1]) begin
         // Extra top bit catches magnitude overflow.
         mag_sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
         if (mag_sum[N-1]) begin
            r = {a[N-1], {(N-1){1'b1}}};
         end else begin
            r = {a[N-1], mag_sum[N-2:0]};
         end
      end else if (a[N-2:0] >= b[N-2:0]) begin
         r = {a[N-1], a[N-2:0] - b[N-2:0]};
      end else begin
         r = {b[N-1], b[N-2:0] - a[N-2:0]};
      end
      if (r[N-2:0] == '0) begin
         r = '0;
      end
      return r;
   endfunction

   function automatic logic [N-1:0] sm_sub(input logic [N-1:0] a, input logic [N-1:0] b);
      return sm_add(a, {~b[N-1], b[N-2:0]});
   endfunction

   // Strict a > b; a zero magnitude is treated as positive so -0 == +0.
   function automatic logic sm_gt(input logic [N-1:0] a, input logic [N-1:0] b);
      logic sa;
      logic sb;
      logic r;
      sa = a[N-1] & (a[N-2:0] != '0);
      sb = b[N-1] & (b[N-2:0] != '0);
      if (sa != sb) begin
         r = ~sa;
      end else if (!sa) begin
         r = a[N-2:0] > b[N-2:0];
      end else begin
         r = a[N-2:0] < b[N-2:0];
      end
      return r;
   endfunction

   state_t            state_q;
   logic [CHW-1:0]    ch_q;
   logic              mode_q;
   logic [CH*N-1:0]   x_q;
   logic [CH*N-1:0]   xp_q;
   logic [N-1:0]      offset_q;
   logic [N-1:0]      hi_q;
   logic [N-1:0]      lo_q;
   logic [N-1:0]      dreg_q;
   logic [CH*N-1:0]   diff_q;
   logic [CH-1:0]     gt_q;
   logic [CH-1:0]     lt_q;
   logic [CW-1:0]     count_q;
   logic              busy_q;
   logic              done_q;

   logic [N-1:0]      x_sel;
   logic [N-1:0]      xp_sel;
   logic [N-1:0]      dreg_d;
   logic              gt_d;
   logic              lt_d;

   // Shared datapath: channel mux, one subtractor, one pair of comparators.
   always_comb begin
      x_sel  = x_q[int'(ch_q)*N +: N];
      xp_sel = xp_q[int'(ch_q)*N +: N];
      dreg_d = mode_q ? sm_sub(xp_sel, offset_q) : sm_sub(x_sel, xp_sel);
      if (mode_q) begin
         gt_d = sm_gt(x_sel, dreg_q);
         lt_d = sm_gt(dreg_q, x_sel);
      end else begin
         gt_d = sm_gt(dreg_q, hi_q);
         lt_d = sm_gt(lo_q, dreg_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         ch_q     <= '0;
         mode_q   <= 1'b0;
         x_q      <= '0;
         xp_q     <= '0;
         offset_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         dreg_q   <= '0;
         diff_q   <= '0;
         gt_q     <= '0;
         lt_q     <= '0;
         count_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  mode_q   <= mode;
                  x_q      <= x_in;
                  xp_q     <= xp_in;
                  offset_q <= offset;
                  hi_q     <= hi_th;
                  lo_q     <= lo_th;
                  count_q  <= '0;
                  ch_q     <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_SUB;
               end
            end
            S_SUB: begin
               dreg_q  <= dreg_d;
               state_q <= S_CMP;
            end
            S_CMP: begin
               diff_q[int'(ch_q)*N +: N] <= dreg_q;
               gt_q[ch_q] <= gt_d;
               lt_q[ch_q] <= lt_d;
               if (gt_d) begin
                  count_q <= count_q + CW'(1);
               end
               if (ch_q == CHW'(CH - 1)) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  ch_q    <= ch_q + CHW'(1);
                  state_q <= S_SUB;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign diff_out = diff_q;
   assign gt_flags = gt_q;
   assign lt_flags = lt_q;
   assign count_gt = count_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_qdiff_thresh_seq.sv
// tb/tb_qdiff_thresh_seq.sv - self-checking bench for qdiff_thresh_seq
module tb_qdiff_thresh_seq;

   localparam int N = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // CH=4 instance
   logic           start4, mode4;
   logic [4*N-1:0] x4, xp4, diff4;
   logic [N-1:0]   off4, hi4, lo4;
   logic [3:0]     gt4, lt4;
   logic [2:0]     cnt4;
   logic           busy4, done4;

   // CH=2 instance
   logic           start2, mode2;
   logic [2*N-1:0] x2, xp2, diff2;
   logic [N-1:0]   off2, hi2, lo2;
   logic [1:0]     gt2, lt2;
   logic [1:0]     cnt2;
   logic           busy2, done2;

   qdiff_thresh_seq #(.N(N), .Q(16), .CH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .mode(mode4),
      .x_in(x4), .xp_in(xp4), .offset(off4), .hi_th(hi4), .lo_th(lo4),
      .diff_out(diff4), .gt_flags(gt4), .lt_flags(lt4), .count_gt(cnt4),
      .busy(busy4), .done(done4)
   );

   qdiff_thresh_seq #(.N(N), .Q(16), .CH(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .mode(mode2),
      .x_in(x2), .xp_in(xp2), .offset(off2), .hi_th(hi2), .lo_th(lo2),
      .diff_out(diff2), .gt_flags(gt2), .lt_flags(lt2), .count_gt(cnt2),
      .busy(busy2), .done(done2)
   );

   typedef struct {
      logic [4*N-1:0] diff;
      logic [3:0]     gt;
      logic [3:0]     lt;
      logic [2:0]     cnt;
   } exp_t;

   exp_t sbq[$];
   int   ntests = 0;
   int   nfail  = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: sign-magnitude word as a plain integer value.
   localparam longint MAXM = 64'sd2147483647;

   function automatic longint val(input logic [31:0] a);
      longint m;
      m = longint'({33'd0, a[30:0]});
      return a[31] ? -m : m;
   endfunction

   function automatic logic [31:0] enc(input longint r);
      longint c;
      logic [31:0] w;
      c = r;
      if (c > MAXM)  c = MAXM;
      if (c < -MAXM) c = -MAXM;
      if (c < 0) begin
         c = -c;
         w = {1'b1, c[30:0]};
      end else begin
         w = {1'b0, c[30:0]};
      end
      return w;
   endfunction

   function automatic logic [31:0] rnd_sm();
      logic [31:0] r;
      int sel;
      sel = $urandom_range(0, 5);
      r = $urandom();
      case (sel)
         0: r = 32'h8000_0000;
         1: r = 32'h0000_0000;
         2: r = {r[31], 16'h7FFF, r[14:0]};
         3: r = {r[31], 16'h7FFF, 15'h7FFF};
         default: ;
      endcase
      return r;
   endfunction

   // Pushes the model's prediction, drives operands and raises start.
   task automatic launch4(input logic m, input logic [4*N-1:0] x, input logic [4*N-1:0] xp,
                          input logic [N-1:0] off, input logic [N-1:0] hi, input logic [N-1:0] lo);
      exp_t e;
      logic [31:0] d, xc, xpc;
      e.cnt = '0;
      e.diff = '0;
      for (int c = 0; c < 4; c++) begin
         xc  = x[c*N +: N];
         xpc = xp[c*N +: N];
         if (m) begin
            d = enc(val(xpc) - val(off));
            e.gt[c] = val(xc) > val(d);
            e.lt[c] = val(xc) < val(d);
         end else begin
            d = enc(val(xc) - val(xpc));
            e.gt[c] = val(d) > val(hi);
            e.lt[c] = val(d) < val(lo);
         end
         e.diff[c*N +: N] = d;
         e.cnt = e.cnt + {2'b0, e.gt[c]};
      end
      sbq.push_back(e);
      mode4 = m; x4 = x; xp4 = xp; off4 = off; hi4 = hi; lo4 = lo;
      start4 = 1'b1;
   endtask

   // Runs cycles until done, pulsing start at p1/p2, then scores the result.
   task automatic wait4(input int p1, input int p2);
      int   kd;
      bit   seen;
      exp_t e;
      kd = 0;
      seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         start4 = (k == p1) || (k == p2);
         if (k == 1) begin
            x4 = {$urandom(), $urandom(), $urandom(), $urandom()};
            xp4 = {$urandom(), $urandom(), $urandom(), $urandom()};
            off4 = $urandom(); hi4 = $urandom(); lo4 = $urandom(); mode4 = ~mode4;
         end
         if (done4) begin
            seen = 1'b1;
            kd = k;
         end
         chk("busy", {127'd0, busy4}, 128'd1);
      end
      chk("done_cycle", 128'(kd), 128'd9);
      if (sbq.size() == 0) begin
         chk("scoreboard_empty", 128'd1, 128'd0);
      end else begin
         e = sbq.pop_front();
         chk("diff", diff4, e.diff);
         chk("gt", {124'd0, gt4}, {124'd0, e.gt});
         chk("lt", {124'd0, lt4}, {124'd0, e.lt});
         chk("count_gt", {125'd0, cnt4}, {125'd0, e.cnt});
      end
   endtask

   function automatic logic [4*N-1:0] rep4(input logic [31:0] w);
      return {w, w, w, w};
   endfunction

   initial begin
      int  kd;
      bit  sawdone;
      logic [4*N-1:0] rx, rxp;
      exp_t junk;

      rst = 1'b0;
      start4 = 0; mode4 = 0; x4 = '0; xp4 = '0; off4 = '0; hi4 = '0; lo4 = '0;
      start2 = 0; mode2 = 0; x2 = '0; xp2 = '0; off2 = '0; hi2 = '0; lo2 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      chk("reset_diff", diff4, '0);
      chk("reset_flags", {120'd0, gt4, lt4}, '0);
      chk("reset_cnt_busy_done", {123'd0, cnt4, busy4, done4}, '0);

      // CH=2 directed mode-0 run
      mode2 = 0; hi2 = 32'h0000_8000; lo2 = 32'h0000_3333;
      x2 = {32'h0000_4000, 32'h0001_0000}; xp2 = {32'h0000_2000, 32'h8002_0000};
      start2 = 1'b1;
      kd = 0;
      for (int k = 1; k <= 20 && kd == 0; k++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (done2) kd = k;
      end
      chk("ch2_done_cycle", 128'(kd), 128'd5);
      chk("ch2_diff0", {96'd0, diff2[31:0]}, 128'h0003_0000);
      chk("ch2_diff1", {96'd0, diff2[63:32]}, 128'h0000_2000);
      chk("ch2_gt", {126'd0, gt2}, 128'b01);
      chk("ch2_lt", {126'd0, lt2}, 128'b10);
      chk("ch2_cnt", {126'd0, cnt2}, 128'd1);

      // Mode 1: equality then less-than
      launch4(1'b1, rep4(32'h800C_0000), rep4(32'h8002_0000), 32'h000A_0000, '0, '0);
      wait4(0, 0);
      chk("m1_diff", {96'd0, diff4[31:0]}, 128'h800C_0000);
      chk("m1_eq_flags", {120'd0, gt4, lt4}, '0);
      @(negedge clk);
      launch4(1'b1, rep4(32'h800D_0000), rep4(32'h8002_0000), 32'h000A_0000, '0, '0);
      wait4(0, 0);
      chk("m1_lt_flags", {120'd0, gt4, lt4}, 128'h0F);

      // Saturation and zero
      @(negedge clk);
      launch4(1'b0, rep4(32'h7FFF_0000), rep4(32'h8001_0000), 32'h0, 32'h0000_8000, 32'h0);
      wait4(0, 0);
      chk("sat_diff", {96'd0, diff4[31:0]}, 128'h7FFF_FFFF);
      chk("sat_gt", {124'd0, gt4}, 128'hF);
      @(negedge clk);
      launch4(1'b0, rep4(32'h0001_0000), rep4(32'h0001_0000), 32'h0, 32'h0, 32'h8000_0000);
      wait4(0, 0);
      chk("zero_diff", diff4, '0);
      chk("zero_lt", {124'd0, lt4}, '0);

      // Handshake: mid-run and done-cycle starts ignored, IDLE start accepted
      @(negedge clk);
      launch4(1'b0, {$urandom(), $urandom(), $urandom(), $urandom()},
              {$urandom(), $urandom(), $urandom(), $urandom()}, 0, $urandom(), $urandom());
      wait4(3, 9);
      @(negedge clk);
      chk("idle_after_done", {126'd0, busy4, done4}, '0);
      launch4(1'b0, {$urandom(), $urandom(), $urandom(), $urandom()},
              {$urandom(), $urandom(), $urandom(), $urandom()}, 0, $urandom(), $urandom());
      wait4(0, 0);
      chk("queue_drained", 128'(sbq.size()), 128'd0);

      // Reset during CMP of ch1 (cycle 4)
      @(negedge clk);
      launch4(1'b0, rep4(32'h0005_0000), rep4(32'h0001_0000), 0, 32'h0, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         start4 = 1'b0;
      end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      junk = sbq.pop_front();
      chk("rst_mid_diff", diff4, '0);
      chk("rst_mid_rest", {120'd0, gt4, lt4}, '0);
      chk("rst_mid_ctl", {123'd0, cnt4, busy4, done4}, '0);
      sawdone = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done4 || busy4) sawdone = 1'b1;
      end
      chk("rst_no_done", {127'd0, sawdone}, '0);
      launch4(1'b0, rep4(32'h0005_0000), rep4(32'h0001_0000), 0, 32'h0, 32'h0);
      wait4(0, 0);

      // Randomised regression, both modes
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
               rx[c*N +: N]  = rnd_sm();
               rxp[c*N +: N] = rnd_sm();
            end
            launch4(m[0], rx, rxp, rnd_sm(), rnd_sm(), rnd_sm());
            wait4(0, 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
